// File: rtl/bird_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bird_pkg
// Description : Shared state encoding and default physics values for the
//               bird motion controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bird_pkg;

  // Default physics and screen geometry
  localparam int DEF_Y_W     = 7;
  localparam int DEF_V_W     = 5;
  localparam int DEF_Y_MIN   = 0;
  localparam int DEF_Y_MAX   = 115;
  localparam int DEF_Y_START = 60;
  localparam int DEF_GRAVITY = 1;
  localparam int DEF_FLAP_V  = 5;
  localparam int DEF_V_MAX   = 7;

  // State encoding
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_READY  = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd1;
  localparam logic [STATE_W-1:0] ST_ERASE  = 3'd2;
  localparam logic [STATE_W-1:0] ST_UPDATE = 3'd3;
  localparam logic [STATE_W-1:0] ST_DRAW   = 3'd4;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    S_READY  = ST_READY,
    S_WAIT   = ST_WAIT,
    S_ERASE  = ST_ERASE,
    S_UPDATE = ST_UPDATE,
    S_DRAW   = ST_DRAW,
    S_STOP   = ST_STOP
  } state_t;

endpackage
`default_nettype wire

// File: rtl/key_edge.sv
`default_nettype none
// ============================================================================
// Module      : key_edge
// Description : Turns the level flap button into a one-cycle rising-edge
//               pulse so a held key yields exactly one flap.
// Revision    : 1.0 - initial release
// ============================================================================
module key_edge
  import bird_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic key,
  output logic key_rise
);

  logic r_key_d;

  // Remember last cycle's key level
  always_ff @(posedge clk) begin
    if (!resetn) r_key_d <= 1'b0;
    else         r_key_d <= key;
  end

  assign key_rise = key & ~r_key_d;

endmodule
`default_nettype wire

// File: rtl/bird_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bird_motion_ctrl
// Description : Frame-driven bird physics and erase/update/draw sequencing
//               for the flappy-bird game.
// Revision    : 1.0 - initial release
// ============================================================================
module bird_motion_ctrl
  import bird_pkg::*;
#(
  parameter int Y_W     = DEF_Y_W,
  parameter int V_W     = DEF_V_W,
  parameter int Y_MIN   = DEF_Y_MIN,
  parameter int Y_MAX   = DEF_Y_MAX,
  parameter int Y_START = DEF_Y_START,
  parameter int GRAVITY = DEF_GRAVITY,
  parameter int FLAP_V  = DEF_FLAP_V,
  parameter int V_MAX   = DEF_V_MAX
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           tick,
  input  logic           press_key,
  input  logic           touched,
  input  logic           draw_done,
  output logic           draw_req,
  output logic           erase,
  output logic [Y_W-1:0] bird_y,
  output logic           game_over,
  output logic           playing
);

  localparam logic        [Y_W-1:0] c_y_start  = Y_W'(Y_START);
  localparam logic        [Y_W-1:0] c_y_min    = Y_W'(Y_MIN);
  localparam logic        [Y_W-1:0] c_y_max    = Y_W'(Y_MAX);
  localparam logic signed [Y_W+1:0] c_y_min_s  = (Y_W+2)'(Y_MIN);
  localparam logic signed [Y_W+1:0] c_y_max_s  = (Y_W+2)'(Y_MAX);
  localparam logic signed [V_W-1:0] c_neg_flap = V_W'(-FLAP_V);
  localparam logic signed [V_W:0]   c_gravity  = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0]   c_v_max    = (V_W+1)'(V_MAX);
  localparam logic signed [V_W-1:0] c_v_max_n  = V_W'(V_MAX);

  state_t                 r_state, w_next_state;
  logic        [Y_W-1:0]  r_y;
  logic signed [V_W-1:0]  r_vel;
  logic                   r_flap_pending;
  logic                   r_hit_pending;
  logic                   r_collide;

  logic                   w_flap;
  logic                   w_flap_now;
  logic                   w_hit_now;
  logic signed [V_W:0]    w_vel_sum;
  logic signed [V_W-1:0]  w_vel_new;
  logic signed [Y_W+1:0]  w_y_sum;
  logic        [Y_W-1:0]  w_y_next;
  logic                   w_clamp;

  key_edge u_key_edge (
    .clk      (clk),
    .resetn   (resetn),
    .key      (press_key),
    .key_rise (w_flap)
  );

  // A flap or hit arriving during the UPDATE cycle itself still counts for it
  assign w_flap_now = r_flap_pending | w_flap;
  assign w_hit_now  = r_hit_pending | touched;

  // Gravity with terminal velocity, or an upward kick on a flap
  assign w_vel_sum = {r_vel[V_W-1], r_vel} + c_gravity;
  assign w_vel_new = w_flap_now ? c_neg_flap
                   : ((w_vel_sum > c_v_max) ? c_v_max_n : w_vel_sum[V_W-1:0]);
  assign w_y_sum   = {2'b00, r_y} + {{(Y_W+2-V_W){w_vel_new[V_W-1]}}, w_vel_new};

  // Clamp the new position to the screen and flag a boundary hit
  always_comb begin
    w_y_next = w_y_sum[Y_W-1:0];
    w_clamp  = 1'b0;
    if (w_y_sum < c_y_min_s) begin
      w_y_next = c_y_min;
      w_clamp  = 1'b1;
    end else if (w_y_sum > c_y_max_s) begin
      w_y_next = c_y_max;
      w_clamp  = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_READY;
    else         r_state <= w_next_state;
  end

  // Next-state logic and Moore outputs
  always_comb begin
    w_next_state = r_state;
    draw_req     = 1'b0;
    erase        = 1'b0;
    game_over    = 1'b0;
    playing      = 1'b0;
    case (r_state)
      S_READY: begin
        if (w_flap) w_next_state = S_DRAW;
      end
      S_WAIT: begin
        playing = 1'b1;
        if (tick) w_next_state = S_ERASE;
      end
      S_ERASE: begin
        playing  = 1'b1;
        draw_req = 1'b1;
        erase    = 1'b1;
        if (draw_done) w_next_state = S_UPDATE;
      end
      S_UPDATE: begin
        playing      = 1'b1;
        w_next_state = S_DRAW;
      end
      S_DRAW: begin
        playing  = 1'b1;
        draw_req = 1'b1;
        if (draw_done) w_next_state = r_collide ? S_STOP : S_WAIT;
      end
      S_STOP: begin
        game_over = 1'b1;
        if (w_flap) w_next_state = S_READY;
      end
      default: w_next_state = S_READY;
    endcase
  end

  // Bird position, velocity and pending-event flags
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_y            <= c_y_start;
      r_vel          <= '0;
      r_flap_pending <= 1'b0;
      r_hit_pending  <= 1'b0;
      r_collide      <= 1'b0;
    end else begin
      case (r_state)
        S_READY: begin
          r_y            <= c_y_start;
          r_vel          <= w_flap ? c_neg_flap : '0;
          r_flap_pending <= 1'b0;
          r_hit_pending  <= 1'b0;
          r_collide      <= 1'b0;
        end
        S_WAIT, S_ERASE, S_DRAW: begin
          if (w_flap)  r_flap_pending <= 1'b1;
          if (touched) r_hit_pending  <= 1'b1;
        end
        S_UPDATE: begin
          r_vel          <= w_vel_new;
          r_y            <= w_y_next;
          r_collide      <= w_clamp | w_hit_now;
          r_flap_pending <= 1'b0;
          r_hit_pending  <= w_hit_now;
        end
        default: ;
      endcase
    end
  end

  assign bird_y = r_y;

endmodule
`default_nettype wire

// File: tb/tb_bird_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bird_motion_ctrl
// Description : Scoreboard bench for bird_motion_ctrl with a frame-level
//               physics model and randomized flaps, hits and drawer delays.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bird_motion_ctrl;

  localparam int Y_START = 60;
  localparam int Y_MIN   = 0;
  localparam int Y_MAX   = 115;
  localparam int GRAVITY = 1;
  localparam int FLAP_V  = 5;
  localparam int V_MAX   = 7;

  localparam int EV_ERASE = 0;
  localparam int EV_DRAW  = 1;
  localparam int EV_STOP  = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b0;
  logic       press_key = 1'b0;
  logic       touched = 1'b0;
  logic       draw_done = 1'b0;
  logic       draw_req;
  logic       erase;
  logic [6:0] bird_y;
  logic       game_over;
  logic       playing;

  typedef struct {
    int kind;
    int y;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  m_y;
  int  m_vel;
  bit  m_hit;
  logic prev_req = 1'b0;
  logic prev_go = 1'b0;

  bird_motion_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .tick      (tick),
    .press_key (press_key),
    .touched   (touched),
    .draw_done (draw_done),
    .draw_req  (draw_req),
    .erase     (erase),
    .bird_y    (bird_y),
    .game_over (game_over),
    .playing   (playing)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int y);
    ev_t e;
    e.kind = kind;
    e.y    = y;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input int y);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d y %0d expected none", kind, y);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_y", y, e.y);
    end
  endtask

  // Monitor: every new draw request and every entry into game over is checked
  always @(negedge clk) begin
    if (draw_req && !prev_req) pop_check(erase ? EV_ERASE : EV_DRAW, int'(bird_y));
    if (game_over && !prev_go) pop_check(EV_STOP, int'(bird_y));
    prev_req = draw_req;
    prev_go  = game_over;
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (draw_req) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL draw_req_timeout: got 0 expected 1 at %0t", $time);
  endtask

  // Acts as the pixel drawer for one request, injecting side events
  task automatic serve(input bit touch_now, input bit spur_tick, input bit flap_now);
    bit ok;
    int n;
    wait_req(ok);
    if (!ok) return;
    if (flap_now) press_key = 1'b1;
    touched = touch_now;
    tick    = spur_tick;
    n = $urandom_range(0, 2);
    repeat (n) begin
      @(negedge clk);
      touched = 1'b0;
      tick    = 1'b0;
    end
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    touched   = 1'b0;
    tick      = 1'b0;
  endtask

  task automatic start_game();
    if (press_key) begin
      press_key = 1'b0;
      @(negedge clk);
    end
    m_y   = Y_START;
    m_vel = -FLAP_V;
    m_hit = 1'b0;
    push_ev(EV_DRAW, m_y);
    press_key = 1'b1;
    @(negedge clk);
    serve(1'b0, 1'b0, 1'b0);
    check("playing_after_start", int'(playing), 1);
  endtask

  // One frame from WAIT; touch_mode 0 none, 1 during erase, 2 during draw
  task automatic frame(input bit flap, input int touch_mode, input bit hold, output bit col);
    int  ny;
    bit  clamped;
    if (flap && press_key) press_key = 1'b0;
    else if (!flap && !hold && press_key && ($urandom_range(0, 1) == 1)) press_key = 1'b0;
    push_ev(EV_ERASE, m_y);
    if (touch_mode == 1) m_hit = 1'b1;
    if (flap) m_vel = -FLAP_V;
    else      m_vel = (m_vel + GRAVITY > V_MAX) ? V_MAX : m_vel + GRAVITY;
    ny      = m_y + m_vel;
    clamped = 1'b0;
    if (ny < Y_MIN) begin ny = Y_MIN; clamped = 1'b1; end
    if (ny > Y_MAX) begin ny = Y_MAX; clamped = 1'b1; end
    col = clamped | m_hit;
    m_y = ny;
    push_ev(EV_DRAW, m_y);
    if (col) push_ev(EV_STOP, m_y);
    if (touch_mode == 2) m_hit = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    serve(touch_mode == 1, 1'($urandom_range(0, 1)), flap);
    serve(touch_mode == 2, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // From STOP: check the frozen bird, ignore ticks, flap back to READY
  task automatic restart();
    check("game_over_in_stop", int'(game_over), 1);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    press_key = 1'b0;
    @(negedge clk);
    check("stop_ignores_tick", int'(game_over), 1);
    check("stop_bird_frozen", int'(bird_y), m_y);
    press_key = 1'b1;
    repeat (4) @(negedge clk);
    check("ready_not_playing", int'(playing), 0);
    check("ready_no_draw", int'(draw_req), 0);
    check("ready_no_game_over", int'(game_over), 0);
    check("ready_bird_y", int'(bird_y), Y_START);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    press_key = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    bit col;
    @(negedge clk);
    repeat (2) @(negedge clk);
    check("reset_draw_req", int'(draw_req), 0);
    check("reset_erase", int'(erase), 0);
    check("reset_game_over", int'(game_over), 0);
    check("reset_playing", int'(playing), 0);
    check("reset_bird_y", int'(bird_y), Y_START);
    resetn = 1'b1;
    @(negedge clk);

    // Free fall to the bottom bound, with one flap held for ten frames
    start_game();
    for (int i = 0; i < 5; i++) frame(1'b0, 0, 1'b0, col);
    frame(1'b1, 0, 1'b1, col);
    for (int i = 0; i < 10 && !col; i++) frame(1'b0, 0, 1'b1, col);
    for (int i = 0; i < 40 && !col; i++) frame(1'b0, 0, 1'b0, col);
    check("fell_to_bottom", m_y, Y_MAX);
    restart();

    // Hit during erase finishes the frame then stops
    start_game();
    frame(1'b0, 1, 1'b0, col);
    check("touch_collides", int'(col), 1);
    restart();

    // Randomized games
    for (int g = 0; g < 6; g++) begin
      start_game();
      col = 1'b0;
      for (int f = 0; f < 200 && !col; f++) begin
        int r;
        int tm;
        r  = $urandom_range(0, 39);
        tm = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
        frame($urandom_range(0, 2) == 0, tm, 1'b0, col);
      end
      if (col) restart();
      else do_reset();
    end

    // Reset while the bird draw request is outstanding
    if (press_key) begin
      press_key = 1'b0;
      @(negedge clk);
    end
    push_ev(EV_DRAW, Y_START);
    press_key = 1'b1;
    @(negedge clk);
    check("pre_reset_draw_req", int'(draw_req), 1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("abandon_draw_req", int'(draw_req), 0);
    check("abandon_playing", int'(playing), 0);
    check("abandon_bird_y", int'(bird_y), Y_START);

    start_game();
    frame(1'b0, 0, 1'b0, col);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL sim_timeout: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
